// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues one memory read per accepted PC, pairs each
// returned word with its PC, and queues the pairs in order for decode.
// A flush empties the queue and discards every fetch still in flight.
module fetch_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] ir_pc_plus4,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Pending-PC FIFO: PCs of granted requests whose data has not returned.
  logic [ADDR_W-1:0] pend_mem [DEPTH];
  logic [PW-1:0]     pend_wr;
  logic [PW-1:0]     pend_rd;

  // Instruction FIFO: {word, PC} pairs waiting for decode.
  logic [DATA_W-1:0] ir_data_mem [DEPTH];
  logic [ADDR_W-1:0] ir_pc_mem   [DEPTH];
  logic [PW-1:0]     ir_wr;
  logic [PW-1:0]     ir_rd;

  logic [CW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;

  logic credit;
  logic grant;
  logic rsp;
  logic keep;
  logic pop;

  // Request path, response classification and output view of the queue head.
  always_comb begin
    // Room must exist for every word that could come back, queued or not.
    credit    = ({1'b0, occ} + {1'b0, outstanding}) < DEPTH_C;
    imem_req  = pc_valid & credit & ~flush;
    imem_addr = pc_in;
    pc_ready  = imem_req & imem_gnt;
    grant     = pc_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp       = imem_rvalid & (outstanding != '0);
    keep      = rsp & (drop_cnt == '0) & ~flush;
    ir_valid  = (occ != '0);
    pop       = ir_valid & ir_ready & ~flush;
    outstanding_next = outstanding + CW'(grant) - CW'(rsp);
    // Head is forced to zero when empty so reset shows clean outputs.
    ir_data     = ir_valid ? ir_data_mem[ir_rd] : '0;
    ir_pc       = ir_valid ? ir_pc_mem[ir_rd] : '0;
    ir_pc_plus4 = ir_valid ? (ir_pc_mem[ir_rd] + ADDR_W'(4)) : '0;
    busy        = (occ != '0) | (outstanding != '0) | (drop_cnt != '0);
  end

  // Pointers, occupancy, in-flight and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      pend_wr     <= '0;
      pend_rd     <= '0;
      ir_wr       <= '0;
      ir_rd       <= '0;
      occ         <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (grant) pend_wr <= pend_wr + PW'(1);
      // The pending PC is retired for every response, discarded or not.
      if (rsp)   pend_rd <= pend_rd + PW'(1);
      if (flush) begin
        drop_cnt <= outstanding_next;
        occ      <= '0;
        ir_rd    <= ir_wr;
      end else begin
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (keep) ir_wr <= ir_wr + PW'(1);
        if (pop)  ir_rd <= ir_rd + PW'(1);
        occ <= occ + CW'(keep) - CW'(pop);
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; pointers and occ define which entries are live.
    if (grant) pend_mem[pend_wr] <= pc_in;
    if (keep) begin
      ir_data_mem[ir_wr] <= imem_rdata;
      ir_pc_mem[ir_wr]   <= pend_mem[pend_rd];
    end
  end

  // Stray responses are tolerated by the logic but reported.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(imem_rvalid && (outstanding == '0)))
    else $warning("fetch_buffer: imem_rvalid with no outstanding request");

  // Queue plus in-flight words can never exceed the buffer size.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (({1'b0, occ} + {1'b0, outstanding}) <= DEPTH_C))
    else $error("fetch_buffer: occupancy plus outstanding exceeds DEPTH");

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a combinational vector table, directed multi-cycle
// sequences and a randomized run, all checked against a queue-based model.
module tb_fetch_buffer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic [ADDR_W-1:0] ir_pc_plus4;
  logic              busy;

  fetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_pc_plus4(ir_pc_plus4), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: fetches in flight (with a discard mark) and the decode queue.
  typedef struct { logic [7:0] pc; logic doomed; } infl_t;
  typedef struct { logic [7:0] pc; logic [31:0] data; } ir_t;
  typedef struct { logic [7:0] addr; int due; } mreq_t;
  typedef struct {
    logic pc_valid; logic [7:0] pc_in; logic flush; logic gnt;
    logic exp_req; logic exp_ready;
  } vec_t;

  infl_t      infl_q[$];
  ir_t        exp_q[$];
  mreq_t      mem_q[$];
  logic [7:0] popped_q[$];
  logic [7:0] p4_q[$];
  int         pop_cyc_q[$];
  logic [7:0] grant_log[$];
  int         grant_cyc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         pc_left = 0;
  logic [7:0] pc_next = 8'h00;
  int         lat_lo = 1;
  int         lat_hi = 1;
  int         rsp_budget = -1;
  bit         rsp_rand = 0;
  int         stale_cnt = 0;
  bit         mem_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: in-order, per-request latency, optional throttling.
  task automatic mem_drive();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_fire    = 1'b0;
    if (stale_cnt > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      stale_cnt--;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc && rsp_budget != 0 &&
                 (!rsp_rand || ($urandom_range(0, 1) == 1))) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hAA00_0000 + {24'h0, mem_q[0].addr};
      mem_fire    = 1'b1;
    end
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, update model, advance.
  task automatic cycle();
    bit         e_valid, e_credit, e_req, e_ready;
    logic [7:0] e_p4;
    infl_t      f;
    ir_t        h;
    mreq_t      m;
    pc_valid = (pc_left > 0);
    pc_in    = pc_next;
    mem_drive();
    #1;
    e_valid  = (exp_q.size() != 0);
    e_credit = ((exp_q.size() + infl_q.size()) < DEPTH);
    e_req    = pc_valid && e_credit && !flush;
    e_ready  = e_req && imem_gnt;
    check("imem_req", imem_req, e_req);
    check("pc_ready", pc_ready, e_ready);
    check("imem_addr", imem_addr, pc_in);
    check("ir_valid", ir_valid, e_valid);
    check("busy", busy, e_valid || (infl_q.size() != 0));
    if (e_valid) begin
      e_p4 = exp_q[0].pc + 8'd4;
      check("ir_pc", ir_pc, exp_q[0].pc);
      check("ir_data", ir_data, exp_q[0].data);
      check("ir_pc_plus4", ir_pc_plus4, e_p4);
    end
    if (ir_valid && ir_ready && !flush) begin
      popped_q.push_back(ir_pc);
      p4_q.push_back(ir_pc_plus4);
      pop_cyc_q.push_back(cyc);
    end
    if (pc_ready) begin
      grant_log.push_back(pc_in);
      grant_cyc_q.push_back(cyc);
    end
    // Model update, from the model's own predictions.
    if (!flush && e_valid && ir_ready) void'(exp_q.pop_front());
    if (imem_rvalid && infl_q.size() != 0) begin
      f = infl_q.pop_front();
      if (!f.doomed && !flush) begin
        h.pc   = f.pc;
        h.data = imem_rdata;
        exp_q.push_back(h);
      end
    end
    if (flush) begin
      exp_q.delete();
      foreach (infl_q[i]) infl_q[i].doomed = 1'b1;
    end
    if (e_ready) begin
      f.pc     = pc_in;
      f.doomed = 1'b0;
      infl_q.push_back(f);
    end
    // Memory and PC-source update, from what the DUT actually did.
    if (pc_ready) begin
      m.addr = pc_in;
      m.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      mem_q.push_back(m);
      pc_next = pc_next + 8'd4;
      pc_left--;
    end
    if (mem_fire) begin
      void'(mem_q.pop_front());
      if (rsp_budget > 0) rsp_budget--;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    popped_q.delete(); p4_q.delete(); pop_cyc_q.delete();
    grant_log.delete(); grant_cyc_q.delete();
  endtask

  task automatic drain(input int limit);
    pc_left = 0; ir_ready = 1'b1; flush = 1'b0; imem_gnt = 1'b1;
    rsp_budget = -1; rsp_rand = 0;
    for (int i = 0; i < limit && (busy || exp_q.size() != 0 || mem_q.size() != 0); i++) cycle();
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish before limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] e_pc;
    int n;

    pc_in = '0; pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; flush = 1'b0; ir_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_ir_data", ir_data, 32'h0);
    check("rst_ir_pc", ir_pc, 8'h00);
    check("rst_ir_pc_plus4", ir_pc_plus4, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Request-path vectors applied to the empty buffer, withdrawn before the edge.
    vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hFC, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      pc_valid = vecs[i].pc_valid; pc_in = vecs[i].pc_in;
      flush = vecs[i].flush; imem_gnt = vecs[i].gnt;
      #1;
      check($sformatf("vec%0d_imem_req", i), imem_req, vecs[i].exp_req);
      check($sformatf("vec%0d_pc_ready", i), pc_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].pc_in);
      #1;
      pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
      @(negedge clk);
    end
    check("vec_no_state_busy", busy, 1'b0);

    // Stream: three PCs, 1-cycle memory, decode always ready.
    clear_logs();
    imem_gnt = 1'b1; ir_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    pc_next = 8'h00; pc_left = 3;
    repeat (8) cycle();
    check("stream_grants", grant_log.size(), 3);
    check("stream_pops", popped_q.size(), 3);
    if (popped_q.size() == 3 && grant_cyc_q.size() == 3) begin
      check("stream_first_latency", pop_cyc_q[0] - grant_cyc_q[0], 2);
      for (int i = 0; i < 3; i++) begin
        e_pc = 8'(4 * i);
        check($sformatf("stream_pc%0d", i), popped_q[i], e_pc);
        check($sformatf("stream_cyc%0d", i), pop_cyc_q[i] - pop_cyc_q[0], i);
      end
    end

    // Backpressure: decode stalled while six PCs are offered.
    drain(40);
    clear_logs();
    ir_ready = 1'b0; pc_next = 8'h00; pc_left = 6;
    repeat (8) cycle();
    check("bp_grants_while_stalled", grant_log.size(), 4);
    check("bp_pc_ready_low", pc_ready, 1'b0);
    check("bp_pc_valid_held", pc_valid, 1'b1);
    ir_ready = 1'b1;
    repeat (14) cycle();
    check("bp_pops", popped_q.size(), 6);
    check("bp_total_grants", grant_log.size(), 6);
    if (popped_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        e_pc = 8'(4 * i);
        check($sformatf("bp_order%0d", i), popped_q[i], e_pc);
      end
    end
    if (grant_log.size() >= 5) check("bp_resume_pc", grant_log[4], 8'h10);

    // Flush with one entry queued and two in flight.
    drain(40);
    clear_logs();
    ir_ready = 1'b0; pc_next = 8'h20; pc_left = 3; rsp_budget = 1;
    repeat (3) cycle();
    check("fl_setup_ir_valid", ir_valid, 1'b1);
    check("fl_setup_ir_pc", ir_pc, 8'h20);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("fl_ir_valid_after", ir_valid, 1'b0);
    check("fl_busy_after", busy, 1'b1);
    rsp_budget = -1; pc_next = 8'h40; pc_left = 1; ir_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 20 && popped_q.size() == 0; i++) cycle();
    check("fl_pops_seen", popped_q.size(), 1);
    if (popped_q.size() != 0) check("fl_first_pc", popped_q[0], 8'h40);

    // Flush in the same cycle as a response; all three fetches are dropped.
    drain(40);
    clear_logs();
    ir_ready = 1'b0; pc_next = 8'h60; pc_left = 3; rsp_budget = 0;
    repeat (3) cycle();
    check("fr_setup_busy", busy, 1'b1);
    rsp_budget = 1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("fr_resp_consumed", mem_q.size(), 2);
    rsp_budget = -1; ir_ready = 1'b1;
    n = 0;
    while (n < 20 && busy) begin cycle(); n++; end
    check("fr_busy_fell", busy, 1'b0);
    check("fr_cycles_to_idle", n, 2);
    check("fr_nothing_delivered", popped_q.size(), 0);

    // Wrap: ten fetches through 0xFC with variable latency.
    drain(40);
    clear_logs();
    lat_lo = 1; lat_hi = 3; ir_ready = 1'b1; pc_next = 8'hE8; pc_left = 10;
    for (int i = 0; i < 80 && popped_q.size() < 10; i++) cycle();
    check("wrap_pops", popped_q.size(), 10);
    if (popped_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        e_pc = 8'hE8 + 8'(4 * i);
        check($sformatf("wrap_order%0d", i), popped_q[i], e_pc);
      end
      check("wrap_fc_pc", popped_q[5], 8'hFC);
      check("wrap_fc_plus4", p4_q[5], 8'h00);
    end

    // Asynchronous reset with three fetches outstanding.
    drain(40);
    lat_lo = 3; lat_hi = 3; ir_ready = 1'b0; pc_next = 8'h90; pc_left = 8;
    repeat (3) cycle();
    check("ar_setup_busy", busy, 1'b1);
    pc_left = 0; pc_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ir_valid", ir_valid, 1'b0);
    check("ar_ir_data", ir_data, 32'h0);
    check("ar_ir_pc", ir_pc, 8'h00);
    check("ar_ir_pc_plus4", ir_pc_plus4, 8'h00);
    check("ar_busy", busy, 1'b0);
    check("ar_pc_ready", pc_ready, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("ar_in_reset_ir_valid", ir_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete(); infl_q.delete(); mem_q.delete();
    lat_lo = 1; lat_hi = 1; rsp_budget = -1; ir_ready = 1'b1;
    stale_cnt = 3;
    repeat (4) cycle();
    check("ar_stale_ir_valid", ir_valid, 1'b0);
    check("ar_stale_busy", busy, 1'b0);
    clear_logs();
    pc_next = 8'h80; pc_left = 1;
    for (int i = 0; i < 10 && popped_q.size() == 0; i++) cycle();
    check("ar_recover_pops", popped_q.size(), 1);
    if (popped_q.size() != 0) check("ar_recover_pc", popped_q[0], 8'h80);

    // Randomized traffic against the model.
    lat_lo = 1; lat_hi = 4; rsp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      ir_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      pc_left  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cycle();
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
